// File: rtl/fir_ss_ingress.sv
// rtl/fir_ss_ingress.sv - AXI-Stream slave ingress for the FIR sample FIFO with length/tlast checking
module fir_ss_ingress #(
    parameter int WIDTH    = 32,
    parameter int LEN_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ap_start,
    input  logic [LEN_BITS-1:0] data_length,
    input  logic                ss_tvalid,
    input  logic [WIDTH-1:0]    ss_tdata,
    input  logic                ss_tlast,
    output logic                ss_tready,
    input  logic                fifo_pre_full,
    output logic                fifo_w_valid,
    output logic [WIDTH-1:0]    fifo_data_in,
    output logic                busy,
    output logic                done,
    output logic [LEN_BITS-1:0] sample_cnt,
    output logic                tlast_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] cnt_q;
    logic                tready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic xfer;
    logic last_beat;
    logic start_ok;

    assign xfer      = ss_tvalid & tready_q;
    assign last_beat = (cnt_q == len_q - LEN_BITS'(1));
    assign start_ok  = (state_q == S_IDLE) & ap_start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = (data_length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer && last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // tready is looked ahead from next state and the FIFO's post-cycle occupancy,
    // so the FIFO never sees a push while full and no comb path reaches ss_tready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= (state_d == S_RUN) & ~fifo_pre_full;
            busy_q   <= (state_d == S_RUN);
            done_q   <= (state_d == S_DONE);
            if (start_ok) begin
                len_q <= data_length;
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (xfer) begin
                cnt_q <= cnt_q + LEN_BITS'(1);
                if (ss_tlast != last_beat) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign ss_tready    = tready_q;
    assign fifo_w_valid = xfer;
    assign fifo_data_in = ss_tdata;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_cnt   = cnt_q;
    assign tlast_err    = err_q;

endmodule

// File: tb/tb_fir_ss_ingress.sv
// tb/tb_fir_ss_ingress.sv - self-checking bench for fir_ss_ingress with a FIFO occupancy model
module tb_fir_ss_ingress;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic [31:0] data_length;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;
    logic        fifo_pre_full;
    logic        fifo_w_valid;
    logic [31:0] fifo_data_in;
    logic        busy;
    logic        done;
    logic [31:0] sample_cnt;
    logic        tlast_err;

    int checks = 0;
    int errors = 0;

    fir_ss_ingress #(.WIDTH(32), .LEN_BITS(32)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .ap_start     (ap_start),
        .data_length  (data_length),
        .ss_tvalid    (ss_tvalid),
        .ss_tdata     (ss_tdata),
        .ss_tlast     (ss_tlast),
        .ss_tready    (ss_tready),
        .fifo_pre_full(fifo_pre_full),
        .fifo_w_valid (fifo_w_valid),
        .fifo_data_in (fifo_data_in),
        .busy         (busy),
        .done         (done),
        .sample_cnt   (sample_cnt),
        .tlast_err    (tlast_err)
    );

    always #5 clk = ~clk;

    // FIFO occupancy model and push log
    logic        fifo_pop;
    logic        pop_eff;
    int          occ;
    int          depth;
    int          ovf = 0;
    int          pcnt = 0;
    logic [31:0] plog [0:4095];

    always_comb begin
        pop_eff       = fifo_pop && (occ > 0);
        fifo_pre_full = (occ + int'(fifo_w_valid) - int'(pop_eff)) >= depth;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= 0;
        else        occ <= occ + int'(fifo_w_valid) - int'(pop_eff);
    end

    always @(posedge clk) begin
        if (fifo_w_valid) begin
            plog[pcnt % 4096] <= fifo_data_in;
            pcnt <= pcnt + 1;
            if (occ >= depth) ovf <= ovf + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] beat_d [0:63];
    logic        beat_l [0:63];

    // Drives one run; beats come from beat_d/beat_l, valid/pop by percentage.
    task automatic run_stream(input int len, input int vpct, input int ppct, input int glitch,
                              input logic exp_err, input int exp_lat, input string tag);
        int   idx, cycles, base, bad;
        logic xfer, timed_out;
        idx = 0; cycles = 0; bad = 0; timed_out = 1'b1;
        base = pcnt;
        ap_start = 1'b1; data_length = len;
        cyc();
        ap_start = 1'b0; data_length = 32'hFFFF_FFFF;
        chk({tag, "_start_cnt"}, sample_cnt, 0);
        chk({tag, "_start_err"}, tlast_err, 0);
        chk({tag, "_start_busy"}, busy, (len != 0));
        for (int it = 0; it < 2000; it++) begin
            if (done) begin timed_out = 1'b0; break; end
            if (!ss_tvalid) ss_tvalid = (idx < len) && ($urandom_range(0, 99) < vpct);
            ss_tdata = beat_d[idx % 64];
            ss_tlast = beat_l[idx % 64];
            fifo_pop = ($urandom_range(0, 99) < ppct);
            if (cycles == glitch) begin ap_start = 1'b1; data_length = 2; end
            else ap_start = 1'b0;
            #4;
            xfer = ss_tvalid & ss_tready;
            cyc();
            cycles++;
            if (xfer) begin idx++; ss_tvalid = 1'b0; end
        end
        ap_start = 1'b0; ss_tvalid = 1'b0; ss_tlast = 1'b0; fifo_pop = 1'b0;
        chk({tag, "_timeout"}, timed_out, 0);
        chk({tag, "_cnt"}, sample_cnt, len);
        chk({tag, "_err"}, tlast_err, exp_err);
        if (exp_lat >= 0) chk({tag, "_lat"}, cycles, exp_lat);
        chk({tag, "_pushes"}, pcnt - base, len);
        for (int i = 0; i < len; i++)
            if (plog[(base + i) % 4096] !== beat_d[i]) bad++;
        chk({tag, "_data"}, bad, 0);
        cyc();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_ready"}, ss_tready, 0);
        chk({tag, "_hold_cnt"}, sample_cnt, len);
        fifo_pop = 1'b1;
        repeat (6) cyc();
        fifo_pop = 1'b0;
    endtask

    typedef struct {
        int   len;
        int   tlast_beat;
        int   exp_cnt;
        logic exp_err;
        int   exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   k, base, bad, len, mode, pos;
        logic xfer, e;

        vecs[0] = '{4, 4, 4, 1'b0, 4};
        vecs[1] = '{3, 2, 3, 1'b1, 3};
        vecs[2] = '{1, 1, 1, 1'b0, 1};
        vecs[3] = '{0, 0, 0, 1'b0, 0};
        vecs[4] = '{6, 0, 6, 1'b1, 6};
        vecs[5] = '{5, 5, 5, 1'b0, 5};
        vecs[6] = '{2, 1, 2, 1'b1, 2};

        rst_n = 1'b0; ap_start = 1'b0; data_length = 0; ss_tvalid = 1'b0;
        ss_tdata = 0; ss_tlast = 1'b0; fifo_pop = 1'b0; depth = 4;
        #1;
        chk("rst_ready", ss_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_err", tlast_err, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // Directed table: full throughput, FIFO drained every cycle
        foreach (vecs[v]) begin
            for (int i = 0; i < 64; i++) begin
                beat_d[i] = $urandom;
                beat_l[i] = (i + 1 == vecs[v].tlast_beat);
            end
            run_stream(vecs[v].len, 100, 100, -1, vecs[v].exp_err, vecs[v].exp_lat,
                       $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_tbl_cnt", v), sample_cnt, vecs[v].exp_cnt);
        end

        // FIFO depth 3 with no pops: backpressure, then a single pop admits one beat
        depth = 3; base = pcnt; k = 0;
        ap_start = 1'b1; data_length = 6;
        cyc();
        ap_start = 1'b0;
        ss_tvalid = 1'b1; ss_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin ss_tdata = 100 + i; cyc(); end
        k = 3; ss_tdata = 103;
        chk("bp_cnt3", sample_cnt, 3);
        chk("bp_ready_low", ss_tready, 0);
        repeat (2) cyc();
        chk("bp_hold_cnt", sample_cnt, 3);
        fifo_pop = 1'b1; cyc(); fifo_pop = 1'b0;
        chk("bp_ready_after_pop", ss_tready, 1);
        chk("bp_cnt_before", sample_cnt, 3);
        cyc();
        k = 4; ss_tdata = 104; ss_tlast = 1'b0;
        chk("bp_one_more", sample_cnt, 4);
        chk("bp_ready_low2", ss_tready, 0);
        fifo_pop = 1'b1;
        for (int it = 0; it < 40 && !done; it++) begin
            #4; xfer = ss_tvalid & ss_tready;
            cyc();
            if (xfer) begin
                k++; ss_tdata = 100 + k; ss_tlast = (k == 5);
                if (k == 6) ss_tvalid = 1'b0;
            end
        end
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
        chk("bp_done", done, 1);
        chk("bp_final_cnt", sample_cnt, 6);
        chk("bp_err", tlast_err, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) if (plog[(base + i) % 4096] !== 32'(100 + i)) bad++;
        chk("bp_data", bad, 0);
        repeat (6) cyc();
        fifo_pop = 1'b0; depth = 4;

        // ap_start during RUN must be ignored
        for (int i = 0; i < 64; i++) begin beat_d[i] = $urandom; beat_l[i] = (i == 4); end
        run_stream(5, 100, 100, 2, 1'b0, 5, "glitch");

        // Asynchronous reset in the middle of a run
        ap_start = 1'b1; data_length = 5;
        cyc();
        ap_start = 1'b0; ss_tvalid = 1'b1; ss_tdata = 32'hAA;
        repeat (2) cyc();
        chk("mid_cnt2", sample_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ss_tready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", sample_cnt, 0);
        ss_tvalid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 64; i++) begin beat_d[i] = $urandom; beat_l[i] = (i == 1); end
        run_stream(2, 100, 100, -1, 1'b0, 2, "post_rst");

        // Randomized runs against a sequence-level model of the beat stream
        for (int r = 0; r < 15; r++) begin
            len = $urandom_range(0, 12);
            depth = $urandom_range(1, 4);
            mode = $urandom_range(0, 2);
            pos = $urandom_range(0, 12);
            for (int i = 0; i < 64; i++) begin
                beat_d[i] = $urandom;
                beat_l[i] = (mode == 0) ? (i == len - 1) : (mode == 2) ? (i == pos) : 1'b0;
            end
            e = 1'b0;
            for (int i = 0; i < len; i++) if (beat_l[i] != (i == len - 1)) e = 1'b1;
            run_stream(len, 70, 60, -1, e, -1, $sformatf("rnd%0d", r));
        end

        chk("fifo_overflow", ovf, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
